instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the RV32I core. Holds the program counter and issues single-outstanding requests to instruction memory. It registers each returned word with its PC and presents it to the decoder: opcode from bits [6:2], funct3 from [14:12], funct7_5 from bit 30. It supports downstream stalls and branch/jump redirects, and a redirect discards any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when invalid (addi x0,x0,0)
- clk_in  input  1  core clock
- rst_n_in  input  1  reset; asynchronous, active-low
- imem_req_out  output  1  fetch request valid
- imem_addr_out  output  32  fetch address, always word-aligned
- imem_gnt_in  input  1  request accepted this cycle
- imem_rvalid_in  input  1  response data valid
- imem_rdata_in  input  32  response instruction word
- stall_in  input  1  downstream cannot accept instr_out this cycle
- redirect_in  input  1  branch/jump taken; refetch from redirect_pc_in
- redirect_pc_in  input  32  redirect target
- instr_out  output  32  registered instruction to decoder
- pc_out  output  32  PC of instr_out
- instr_valid_out  output  1  instr_out/pc_out valid
- misaligned_out  output  1  one-cycle pulse: redirect target bits [1:0] != 0

## Operation
- State machine states:
  - RST: entered on reset.
  - REQ: request asserted.
  - WAIT: one request outstanding.
  - FULL: output register holds an unconsumed instruction.
- RST→REQ on first clk_in edge after rst_n_in deasserts.
- REQ: imem_req_out=1 and imem_addr_out=pc_q.
  - On imem_gnt_in: fetch_pc_q<=pc_q, pc_q<=pc_q+4, →WAIT.
- WAIT: imem_req_out=0.
  - On imem_rvalid_in with kill_q=0: instr_out<=imem_rdata_in, pc_out<=fetch_pc_q, instr_valid_out<=1, →FULL.
  - On imem_rvalid_in with kill_q=1: drop the data, clear kill_q, →REQ.
- Consumption: the output is consumed on any cycle with instr_valid_out=1 and stall_in=0.
- FULL with stall_in=1: hold all outputs, imem_req_out=0.
- FULL with stall_in=0:
  - imem_req_out=1 combinationally, with imem_addr_out=pc_q.
  - With imem_gnt_in: →WAIT, doing the same fetch_pc_q/pc_q update as REQ.
  - Without imem_gnt_in: →REQ.
  - In both cases instr_valid_out<=0 and instr_out<=NOP_INSTR.
- Redirect has highest priority in every state except RST, and it ignores stall_in:
  - pc_q<=redirect_pc_in with bits [1:0] forced to 00.
  - instr_valid_out<=0, instr_out<=NOP_INSTR.
  - If a request is outstanding (WAIT), or is granted in the same cycle: kill_q<=1, →WAIT.
  - Otherwise →REQ.
  - A redirect coincident with imem_rvalid_in: drop the data, →REQ.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC→32'h0000_0000 without error.
- Reset mid-operation clears all state immediately. A later stale imem_rvalid_in in RST/REQ is ignored.

## Timing
- Reset values:
  - imem_req_out=0, imem_addr_out=RESET_PC.
  - instr_out=NOP_INSTR, pc_out=RESET_PC.
  - instr_valid_out=0, misaligned_out=0.
  - pc_q=RESET_PC, kill_q=0, state RST.
- Latency: with gnt in the request cycle and rvalid the following cycle, instr_valid_out rises 2 cycles after imem_req_out first asserts.
- Throughput: one instruction per 2 cycles with zero-wait memory and no stall.
- Only one request is outstanding at any time. imem_req_out is never high in WAIT.
- imem_addr_out, instr_out and pc_out are stable while stalled.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc_in[1:0]!=0 pulses misaligned_out for exactly one cycle, the cycle after the redirect. The fetch still proceeds from the aligned address.
- FETCH_MISALIGN_TRAP_EN undefined: misaligned_out is tied to 0. Low bits are silently cleared.

## Test plan
- Reset release, zero-wait memory returning 32'h00500093:
  - imem_addr_out 0x0 then 0x4.
  - instr_out=32'h00500093, pc_out=0x0, instr_valid_out high 2 cycles after first req.
- Instruction valid at pc 0x8, stall_in held high 3 cycles:
  - outputs frozen, imem_req_out=0.
  - Stall released → next request to 0xC.
- Redirect to 0x100 while in WAIT for 0x10; rvalid arrives next cycle with 32'hDEADBEEF:
  - data dropped, instr_valid_out stays 0.
  - Next request to 0x100.
- Redirect to 0x200 coincident with gnt for 0x20:
  - kill set, response for 0x20 discarded.
  - Next request to 0x200.
- Redirect to 0x102 with FETCH_MISALIGN_TRAP_EN:
  - misaligned_out pulses 1 cycle, fetch from 0x100.
  - Without the macro: misaligned_out stays 0.
- rst_n_in asserted while in WAIT:
  - all outputs return to reset values asynchronously.
  - After release, first fetch is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the RV32I core. Holds the program counter, issues one
// instruction-memory request at a time, registers the returned word together
// with its PC and presents it to the decoder. Downstream stalls freeze the
// output register. Branch/jump redirects restart fetch from a new PC and
// discard whatever fetch is still in flight.
//
// Handshakes:
//   imem request : a request is transferred on a cycle where imem_req_out and
//                  imem_gnt_in are both high. imem_addr_out is valid whenever
//                  imem_req_out is high. Exactly one response (imem_rvalid_in
//                  with imem_rdata_in) follows each transferred request, on
//                  any later cycle. A new request is never raised while a
//                  response is still owed.
//   decoder      : instr_out/pc_out are valid while instr_valid_out is high.
//                  They are consumed on any cycle with instr_valid_out=1 and
//                  stall_in=0, and are held unchanged while stall_in=1.
//
// Ports:
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   imem_req_out, imem_addr_out  fetch request and word-aligned address
//   imem_gnt_in                  request accepted this cycle
//   imem_rvalid_in/_rdata_in     response valid and instruction word
//   stall_in                     decoder cannot take instr_out this cycle
//   redirect_in/_pc_in           branch/jump taken, refetch from target
//   instr_out, pc_out            registered instruction and its PC
//   instr_valid_out              instr_out/pc_out valid
//   misaligned_out               one-cycle pulse for a misaligned target
//   opcode_out                   instr_out[6:2]
//   funct3_out                   instr_out[14:12]
//   funct7_5_out                 instr_out[30]
//   fsm_state_out                current fetch state (debug visibility)
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect whose target has
//                           non-zero bits [1:0] pulses misaligned_out on the
//                           following cycle. When undefined misaligned_out is
//                           tied low. Either way the low bits are dropped and
//                           fetch proceeds from the aligned address.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic        misaligned_out,
    output logic [4:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic        funct7_5_out,
    output logic [1:0]  fsm_state_out
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,   // first cycle out of reset, ignores all inputs
        ST_REQ  = 2'd1,   // request raised for pc_q
        ST_WAIT = 2'd2,   // one request outstanding
        ST_FULL = 2'd3    // output register holds an unconsumed instruction
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;        // next address to request
    logic [31:0] fetch_pc_q;  // address of the request in flight
    logic        kill_q;      // in-flight response belongs to a stale path
    logic        granted;
    logic [31:0] redirect_pc_aligned;

    // The request is a function of state only (plus stall in FULL), so the
    // memory side never sees it depend on its own grant.
    assign imem_req_out  = (state_q == ST_REQ) || ((state_q == ST_FULL) && !stall_in);
    assign imem_addr_out = pc_q;
    assign granted       = imem_req_out && imem_gnt_in;

    assign redirect_pc_aligned = {redirect_pc_in[31:2], 2'b00};

    assign opcode_out    = instr_out[6:2];
    assign funct3_out    = instr_out[14:12];
    assign funct7_5_out  = instr_out[30];
    assign fsm_state_out = state_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= ST_RST;
            pc_q            <= RESET_PC;
            fetch_pc_q      <= RESET_PC;
            kill_q          <= 1'b0;
            instr_out       <= NOP_INSTR;
            pc_out          <= RESET_PC;
            instr_valid_out <= 1'b0;
        end else if (state_q == ST_RST) begin
            // Any response still arriving from before reset is ignored here.
            state_q <= ST_REQ;
        end else if (redirect_in) begin
            // Redirect wins over everything, including a stall: the held
            // instruction is on the wrong path and is squashed.
            pc_q            <= redirect_pc_aligned;
            instr_valid_out <= 1'b0;
            instr_out       <= NOP_INSTR;
            if (((state_q == ST_WAIT) && !imem_rvalid_in) || granted) begin
                // A response is still owed; wait for it and throw it away.
                kill_q  <= 1'b1;
                state_q <= ST_WAIT;
            end else begin
                // Nothing owed (or the owed response is arriving right now
                // and is dropped), so the new path can be requested at once.
                kill_q  <= 1'b0;
                state_q <= ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_gnt_in) begin
                        fetch_pc_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_in) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= ST_REQ;
                        end else begin
                            instr_out       <= imem_rdata_in;
                            pc_out          <= fetch_pc_q;
                            instr_valid_out <= 1'b1;
                            state_q         <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    // Stalled: everything holds. Otherwise the instruction is
                    // consumed this cycle and the next fetch overlaps it.
                    if (!stall_in) begin
                        instr_valid_out <= 1'b0;
                        instr_out       <= NOP_INSTR;
                        if (imem_gnt_in) begin
                            fetch_pc_q <= pc_q;
                            pc_q       <= pc_q + 32'd4;
                            state_q    <= ST_WAIT;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                default: state_q <= ST_RST;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_in && (state_q != ST_RST) &&
                            (redirect_pc_in[1:0] != 2'b00);
        end
    end

    assign misaligned_out = misaligned_q;
`else
    // Low target bits are silently dropped in this build.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_in[1:0];
    assign misaligned_out      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed scenarios followed by a randomized phase. The bench plays the
// instruction memory: each address holds a fixed word, grants and response
// delays are chosen by the bench. The reference model tracks the fetch stream
// at the level of "addresses requested in order, restarting at each redirect
// target": each granted request is tagged with the redirect epoch it was
// issued in, and only responses whose epoch is still current (and that do not
// coincide with a redirect) are expected to reach the decoder, in order.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in = 1'b0;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = 32'h0;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid_out;
    logic        misaligned_out;
    logic [4:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic        funct7_5_out;
    logic [1:0]  fsm_state_out;

    always #5 clk_in = ~clk_in;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_gnt_in     (imem_gnt_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_valid_out (instr_valid_out),
        .misaligned_out  (misaligned_out),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_5_out    (funct7_5_out),
        .fsm_state_out   (fsm_state_out)
    );

    // ---------------- scoreboard / model state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];        // {pc, instr} expected at the decoder, in order
    logic [31:0] exp_pc;          // next address the fetch unit should request
    int          epoch = 0;       // bumped by every redirect and reset
    bit          busy = 1'b0;     // a response is owed by the memory
    logic [31:0] busy_addr;
    int          busy_epoch;
    int          busy_delay;
    int          fixed_delay = 0; // <0: random response delay
    bit          prev_valid, prev_stall, prev_redirect;
    logic        exp_mis = 1'b0;
    logic [31:0] prev_instr, prev_pc, prev_addr;
    logic [31:0] last_grant_addr = 32'h0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Memory contents: address 0 holds addi x1,x0,5, the rest a scrambled word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pc        = RESET_PC;
        epoch++;
        busy          = 1'b0;
        prev_valid    = 1'b0;
        prev_stall    = 1'b0;
        prev_redirect = 1'b0;
        exp_mis       = 1'b0;
    endtask

    // Outputs produced by the edge just passed, compared with the model.
    task automatic check_outputs();
        logic [63:0] e;
        logic [31:0] ew;
        check("misaligned", misaligned_out, exp_mis);
        if (!instr_valid_out) check("nop_when_invalid", instr_out, NOP_INSTR);
        if (prev_redirect) begin
            check("valid_after_redirect", instr_valid_out, 1'b0);
        end else if (prev_valid && !prev_stall) begin
            check("valid_after_consume", instr_valid_out, 1'b0);
        end else if (prev_valid) begin
            check("hold_valid", instr_valid_out, 1'b1);
            check("hold_instr", instr_out, prev_instr);
            check("hold_pc", pc_out, prev_pc);
            check("hold_addr", imem_addr_out, prev_addr);
        end else begin
            check("valid_new", instr_valid_out, exp_q.size() != 0);
            if (instr_valid_out === 1'b1 && exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ew = e[31:0];
                check("pc_out", pc_out, e[63:32]);
                check("instr_out", instr_out, ew);
                check("opcode", opcode_out, ew[6:2]);
                check("funct3", funct3_out, ew[14:12]);
                check("funct7_5", funct7_5_out, ew[30]);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            exp_q.delete();
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic s, input logic r, input logic [31:0] rpc, input logic g);
        @(negedge clk_in);
        cyc++;
        check_outputs();
        stall_in       = s;
        redirect_in    = r;
        redirect_pc_in = rpc;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = $urandom();
        if (busy && busy_delay == 0) begin
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = mem_word(busy_addr);
        end
        #1;
        if (busy) check("no_req_while_outstanding", imem_req_out, 1'b0);
        if (instr_valid_out) check("req_in_full", imem_req_out, !s);
        if (imem_req_out) check("addr_aligned", imem_addr_out[1:0], 2'b00);
        if (imem_req_out && first_req_cyc < 0) first_req_cyc = cyc;
        imem_gnt_in = imem_req_out && g;

        // reference model for the coming edge
        if (imem_rvalid_in) begin
            busy = 1'b0;
            if (busy_epoch == epoch && !r) exp_q.push_back({busy_addr, mem_word(busy_addr)});
        end else if (busy) begin
            busy_delay--;
        end
        if (imem_gnt_in) begin
            check("fetch_addr", imem_addr_out, exp_pc);
            last_grant_addr = imem_addr_out;
            busy       = 1'b1;
            busy_addr  = exp_pc;
            busy_epoch = epoch;
            busy_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            exp_pc     = exp_pc + 32'd4;
        end
        if (r) begin
            epoch++;
            exp_pc = {rpc[31:2], 2'b00};
        end
        exp_mis       = r && (rpc[1:0] != 2'b00) && MIS_EN;
        prev_valid    = instr_valid_out;
        prev_stall    = s;
        prev_redirect = r;
        prev_instr    = instr_out;
        prev_pc       = pc_out;
        prev_addr     = imem_addr_out;
    endtask

    // Reset asserted between edges, checked before the next edge arrives,
    // released at a negedge with a stale response on the bus.
    task automatic apply_reset(input int hold_cycles);
        @(negedge clk_in);
        #2;
        rst_n_in    = 1'b0;
        stall_in    = 1'b0;
        redirect_in = 1'b0;
        imem_gnt_in = 1'b0;
        imem_rvalid_in = 1'b0;
        #1;
        check("rst_req", imem_req_out, 1'b0);
        check("rst_addr", imem_addr_out, RESET_PC);
        check("rst_instr", instr_out, NOP_INSTR);
        check("rst_pc_out", pc_out, RESET_PC);
        check("rst_valid", instr_valid_out, 1'b0);
        check("rst_misaligned", misaligned_out, 1'b0);
        repeat (hold_cycles) @(negedge clk_in);
        rst_n_in       = 1'b1;
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = 32'hDEAD_BEEF;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] t;
        int n;

        apply_reset(2);

        // First fetch, zero-wait memory
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x0
        check("first_addr", last_grant_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // response
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // shows 0x0, grant 0x4
        check("first_instr", instr_out, 32'h0050_0093);
        check("first_pc", pc_out, 32'h0);
        check("first_latency", first_valid_cyc - first_req_cyc, 32'd2);
        check("second_addr", last_grant_addr, 32'h4);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // shows 0x4, grant 0x8
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall for three cycles with 0x8 held
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_pc", pc_out, 32'h8);
        check("stall_req", imem_req_out, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_req_end", imem_req_out, 1'b0);
        check("stall_instr_end", instr_out, mem_word(32'h8));
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0xC
        check("after_stall_addr", last_grant_addr, 32'hC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while waiting for 0x10
        fixed_delay = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x10
        fixed_delay = 0;
        check("wait_addr", last_grant_addr, 32'h10);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);               // redirect in WAIT
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // stale response
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x100
        check("killed_not_presented", instr_valid_out, 1'b0);
        check("redirect_addr", last_grant_addr, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect coincident with a grant
        cycle(1'b0, 1'b1, 32'h20, 1'b0);                // redirect from FULL, no grant
        cycle(1'b0, 1'b1, 32'h200, 1'b1);               // grant 0x20 + redirect
        check("granted_then_killed", last_grant_addr, 32'h20);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // stale response
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x200
        check("coincident_redirect_addr", last_grant_addr, 32'h200);
        check("coincident_valid", instr_valid_out, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect while stalled
        cycle(1'b1, 1'b1, 32'h102, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x100
        check("misaligned_pulse", misaligned_out, MIS_EN);
        check("misaligned_fetch", last_grant_addr, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("misaligned_one_cycle", misaligned_out, 1'b0);

        // PC wrap at the top of the address space
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0xFFFFFFFC
        check("top_addr", last_grant_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);                 // grant 0x0
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_addr", last_grant_addr, 32'h0);

        // Randomized traffic
        fixed_delay = -1;
        for (int i = 0; i < 400; i++) begin
            t = $urandom();
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            else t = t & 32'h0000_FFFF;
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, t,
                  $urandom_range(0, 9) < 7);
        end

        // Reset while a request is outstanding
        fixed_delay = 6;
        n = 0;
        while (!busy && n < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("reached_wait", busy, 1'b1);
        apply_reset(3);
        fixed_delay = 0;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_reset_addr", last_grant_addr, RESET_PC);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
